connect4_game_ctrl: RTL

//  Sequences the Connect-4 game state that feeds the VGA pixel colourer: owns the cursor, the
//  6x7 occupancy/colour matrices, turn alternation, animated gravity drop and end-of-game.

---
 rtl/connect4_game_ctrl_if.sv | 38 +++
 rtl/connect4_game_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/connect4_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : connect4_game_ctrl_if
//  Purpose  : Bundles the button/checker inputs and the board/status outputs
//             of the Connect-4 game controller into one interface.
//  Modports : master - button debouncer / win checker / display side
//                      (drives btn_*, new_game and win_i)
//             slave  - the game controller itself
//  Signals  : btn_left, btn_right, btn_drop, new_game, win_i    (to ctrl)
//             posicion[6:0], tablero[5:0][6:0], fichas[5:0][6:0],
//             turn_o, winner_o[1:0], busy_o, illegal_o          (from ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface connect4_game_ctrl_if;
  logic             btn_left;
  logic             btn_right;
  logic             btn_drop;
  logic             new_game;
  logic             win_i;
  logic [6:0]       posicion;
  logic [5:0][6:0]  tablero;
  logic [5:0][6:0]  fichas;
  logic             turn_o;
  logic [1:0]       winner_o;
  logic             busy_o;
  logic             illegal_o;

  modport master (
    output btn_left, btn_right, btn_drop, new_game, win_i,
    input  posicion, tablero, fichas, turn_o, winner_o, busy_o, illegal_o
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, new_game, win_i,
    output posicion, tablero, fichas, turn_o, winner_o, busy_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/connect4_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : connect4_game_ctrl
//  Purpose  : Connect-4 game sequencer. Owns the cursor, the 6x7 occupancy
//             and colour matrices, turn alternation, the animated gravity
//             drop and end-of-game detection (win reported by an external
//             combinational checker on bus.win_i).
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - connect4_game_ctrl_if.slave (buttons, win_i in;
//                      posicion, tablero, fichas, turn_o, winner_o,
//                      busy_o, illegal_o out)
//  Params   : FALL_TICKS    - clk cycles per one-row fall step (>=1)
//             START_COL     - cursor column at reset / new turn (0..6)
//             TIMEOUT_TICKS - turn time limit (TURN_TIMEOUT_EN only)
//  Options  : `define TURN_TIMEOUT_EN adds a per-turn timer that auto-drops
//             at the cursor (or passes the turn if that column is full).
//  Revision : 1.0 - initial release
// ============================================================================
module connect4_game_ctrl #(
  parameter logic [24:0] FALL_TICKS    = 25'd12_500_000,
  parameter int unsigned START_COL     = 3
`ifdef TURN_TIMEOUT_EN
  ,
  parameter logic [28:0] TIMEOUT_TICKS = 29'd500_000_000
`endif
) (
  input wire                  clk,
  input wire                  rst_n,
  connect4_game_ctrl_if.slave bus
);

  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_fall      = 2'd1;
  localparam logic [1:0] c_check     = 2'd2;
  localparam logic [1:0] c_game_over = 2'd3;

  localparam logic [2:0] c_start_col = 3'(START_COL);
  localparam logic [2:0] c_top_row   = 3'd5;
  localparam logic [5:0] c_max_moves = 6'd42;

  logic [1:0]      r_state;
  logic [2:0]      r_cur;
  logic [2:0]      r_row;
  logic [24:0]     r_tick;
  logic [5:0][6:0] r_board;
  logic [5:0][6:0] r_colour;
  logic            r_turn;
  logic [1:0]      r_winner;
  logic            r_illegal;
  logic [5:0]      r_count;

  logic            w_move_left;
  logic            w_move_right;
  logic            w_col_full;
  logic            w_tick_wrap;
  logic [2:0]      w_row_below;
  logic [5:0]      w_count_next;
  logic            w_timeout;
  logic            w_drop_req;

  // Both directions pressed together cancel out.
  assign w_move_left  = bus.btn_left & ~bus.btn_right;
  assign w_move_right = bus.btn_right & ~bus.btn_left;
  assign w_col_full   = r_board[c_top_row][r_cur];
  assign w_tick_wrap  = (r_tick == FALL_TICKS - 25'd1);
  assign w_row_below  = r_row - 3'd1;
  assign w_count_next = r_count + 6'd1;

`ifdef TURN_TIMEOUT_EN
  logic [28:0] r_idle_ticks;

  // Fires on the TIMEOUT_TICKS-th idle cycle, only when no button acts.
  assign w_timeout = (r_state == c_idle) &&
                     (r_idle_ticks == TIMEOUT_TICKS - 29'd1) &&
                     !bus.btn_drop && !w_move_left && !w_move_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_ticks <= 29'd0;
    end else if (bus.new_game || r_state != c_idle) begin
      // Held at zero outside IDLE so every turn starts a fresh count.
      r_idle_ticks <= 29'd0;
    end else if (bus.btn_drop || w_move_left || w_move_right || w_timeout) begin
      r_idle_ticks <= 29'd0;
    end else begin
      r_idle_ticks <= r_idle_ticks + 29'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_drop_req = bus.btn_drop | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_cur     <= c_start_col;
      r_row     <= 3'd0;
      r_tick    <= 25'd0;
      r_board   <= '0;
      r_colour  <= '0;
      r_turn    <= 1'b1;
      r_winner  <= 2'b00;
      r_illegal <= 1'b0;
      r_count   <= 6'd0;
    end else if (bus.new_game) begin
      // Restart from any state, discarding a piece that is mid-fall.
      r_state   <= c_idle;
      r_cur     <= c_start_col;
      r_row     <= 3'd0;
      r_tick    <= 25'd0;
      r_board   <= '0;
      r_colour  <= '0;
      r_turn    <= 1'b1;
      r_winner  <= 2'b00;
      r_illegal <= 1'b0;
      r_count   <= 6'd0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_drop_req) begin
            if (w_col_full) begin
              if (bus.btn_drop) begin
                r_illegal <= 1'b1;
              end else begin
                // Timed-out turn on a full column: pass to the other player.
                r_turn <= ~r_turn;
                r_cur  <= c_start_col;
              end
            end else begin
              // Piece enters at the top row and starts falling.
              r_board[c_top_row][r_cur]  <= 1'b1;
              r_colour[c_top_row][r_cur] <= r_turn;
              r_row   <= c_top_row;
              r_tick  <= 25'd0;
              r_state <= c_fall;
            end
          end else if (w_move_left) begin
            if (r_cur != 3'd6) r_cur <= r_cur + 3'd1;
          end else if (w_move_right) begin
            if (r_cur != 3'd0) r_cur <= r_cur - 3'd1;
          end
        end

        c_fall: begin
          if (w_tick_wrap) begin
            r_tick <= 25'd0;
            if (r_row != 3'd0 && !r_board[w_row_below][r_cur]) begin
              // Move the piece one row down: clear old cell, set new one.
              r_board[r_row][r_cur]        <= 1'b0;
              r_colour[r_row][r_cur]       <= 1'b0;
              r_board[w_row_below][r_cur]  <= 1'b1;
              r_colour[w_row_below][r_cur] <= r_turn;
              r_row <= w_row_below;
            end else begin
              r_state <= c_check;
            end
          end else begin
            r_tick <= r_tick + 25'd1;
          end
        end

        c_check: begin
          r_count <= w_count_next;
          // A win on the last free cell beats the draw.
          if (bus.win_i) begin
            r_winner <= r_turn ? 2'b01 : 2'b10;
            r_state  <= c_game_over;
          end else if (w_count_next == c_max_moves) begin
            r_winner <= 2'b11;
            r_state  <= c_game_over;
          end else begin
            r_turn  <= ~r_turn;
            r_cur   <= c_start_col;
            r_state <= c_idle;
          end
        end

        c_game_over: begin
          // Frozen until new_game.
        end

        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.posicion  = (r_state == c_idle) ? (7'd1 << r_cur) : 7'd0;
  assign bus.tablero   = r_board;
  assign bus.fichas    = r_colour;
  assign bus.turn_o    = r_turn;
  assign bus.winner_o  = r_winner;
  assign bus.busy_o    = (r_state == c_fall) || (r_state == c_check);
  assign bus.illegal_o = r_illegal;

endmodule
`default_nettype wire
